// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen
//
// Serial bit-stream transmitter. A parallel word plus a bit count is taken
// through a valid/ready load handshake, and the selected bits are shifted out
// MSB-first, one bit per clock, on x. Back-to-back loads accepted on the final
// bit cycle of a frame continue the stream with no idle gap.
//
// Optional feature macro: SERIAL_PATTERN_GEN_PARITY_EN
//   defined   : an even-parity bit (XOR of the sent data bits) follows each frame
//   undefined : frames are exactly n data bits
//
// Parameters:
//   WIDTH      maximum frame length and load_data width (2..32)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   load_valid load request present
//   load_ready block can accept a load this cycle (registered)
//   load_data  pattern word; the low n bits are sent
//   load_len   bit count; 0 or > WIDTH means WIDTH
//   x          serial data bit, 0 when x_valid is low
//   x_valid    x carries a frame bit (data or parity)
//   busy       a frame is in progress
//   done       one-cycle pulse in the first idle cycle after a frame

module serial_pattern_gen #(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [WIDTH-1:0]           load_data,
    input  logic [$clog2(WIDTH+1)-1:0] load_len,
    output logic                       x,
    output logic                       x_valid,
    output logic                       busy,
    output logic                       done
);

    localparam int CW = $clog2(WIDTH+1);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    cnt;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
    logic             par;
`endif

    logic             accept;
    logic [CW-1:0]    eff_len;
    logic [WIDTH-1:0] aligned;

    always_comb begin
        accept = load_valid && load_ready;
        if ((load_len == '0) || (load_len > WIDTH_C)) begin
            eff_len = WIDTH_C;
        end else begin
            eff_len = load_len;
        end
        // Left-align the low eff_len bits; the bits above them fall off the top.
        aligned = load_data << (WIDTH_C - eff_len);
    end

    // x always shows the bit for the current cycle; sh holds the bits still
    // to come, already advanced past the one on x.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sh         <= '0;
            cnt        <= '0;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
            par        <= 1'b0;
`endif
            x          <= 1'b0;
            x_valid    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            if (accept) begin
                // load_ready is only high in IDLE or on a frame's final bit,
                // so an accept always starts a fresh frame from here.
                state   <= SHIFT;
                x       <= aligned[WIDTH-1];
                x_valid <= 1'b1;
                busy    <= 1'b1;
                sh      <= {aligned[WIDTH-2:0], 1'b0};
                cnt     <= eff_len;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
                par        <= aligned[WIDTH-1];
                load_ready <= 1'b0;
`else
                load_ready <= (eff_len == CW'(1));
`endif
            end else begin
                case (state)
                    IDLE: begin
                        x       <= 1'b0;
                        x_valid <= 1'b0;
                        busy    <= 1'b0;
                    end
                    SHIFT: begin
                        if (cnt == CW'(1)) begin
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
                            state      <= PARITY;
                            x          <= par;
                            x_valid    <= 1'b1;
                            cnt        <= '0;
                            load_ready <= 1'b1;
`else
                            state      <= IDLE;
                            x          <= 1'b0;
                            x_valid    <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            cnt        <= '0;
                            sh         <= '0;
                            load_ready <= 1'b1;
`endif
                        end else begin
                            x   <= sh[WIDTH-1];
                            sh  <= {sh[WIDTH-2:0], 1'b0};
                            cnt <= cnt - CW'(1);
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
                            par        <= par ^ sh[WIDTH-1];
                            load_ready <= 1'b0;
`else
                            // Next cycle is the last data bit when cnt drops to 1.
                            load_ready <= (cnt == CW'(2));
`endif
                        end
                    end
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
                    PARITY: begin
                        state      <= IDLE;
                        x          <= 1'b0;
                        x_valid    <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        cnt        <= '0;
                        sh         <= '0;
                        par        <= 1'b0;
                        load_ready <= 1'b1;
                    end
`endif
                    default: begin
                        state      <= IDLE;
                        x          <= 1'b0;
                        x_valid    <= 1'b0;
                        busy       <= 1'b0;
                        cnt        <= '0;
                        sh         <= '0;
                        load_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/serial_pattern_gen.md
# serial_pattern_gen

Serial bit-stream transmitter that produces stimulus for the Moore sequence detectors (e.g. the 1001 detector) on real hardware instead of only in simulation. It accepts a parallel word plus a bit count through a valid/ready load handshake and shifts the selected bits out MSB-first, one bit per clock, on `x`. The `x` output connects directly to a detector's `x` input. Back-to-back loads produce a gap-free stream, so patterns can straddle frame boundaries.

## Interface
- `WIDTH`, 16: maximum frame length in bits and width of `load_data`; legal range 2..32.
- `clk` input 1: rising-edge clock.
- `reset` input 1: one clock; reset is synchronous and active-high.
- `load_valid` input 1: a load request is present.
- `load_ready` output 1: the block can accept a load this cycle.
- `load_data` input `WIDTH`: pattern word.
- `load_len` input `$clog2(WIDTH+1)`: number of bits to send. 0 means `WIDTH`; values greater than `WIDTH` clamp to `WIDTH`.
- `x` output 1: serial data bit. Forced to 0 when `x_valid` is 0.
- `x_valid` output 1: `x` carries a frame bit (data or parity) this cycle.
- `busy` output 1: a frame is in progress.
- `done` output 1: one-cycle pulse after the last bit of a frame, when no new frame follows.

## Operation
- States:
  - IDLE: `load_ready`=1, `x_valid`=0.
  - SHIFT: data bits are on `x`.
  - PARITY: parity bit on `x`; only exists with the macro enabled.
- Load accept: `load_valid && load_ready` at a rising edge.
  - Registers `n = effective length`.
  - Registers `sh = load_data[n-1:0]`, left-aligned in the shift register.
  - Bit counter loads with `n`.
  - Next state is SHIFT.
  - `load_data` and `load_len` are don't-care on cycles without an accept.
- SHIFT:
  - `x` = current MSB of the shift register.
  - Each cycle the shift register shifts left by 1 and the counter decrements.
  - On the last data bit (counter == 1), the next state is PARITY if enabled. Otherwise:
    - IDLE if no accept this cycle;
    - SHIFT with the new frame loaded if an accept occurs this cycle.
- Output rule: `load_ready` = 1 in IDLE and on the final bit cycle of a frame (the last data bit, or the parity bit when enabled). It is 0 otherwise.
- `done`: registered pulse asserted in the first IDLE cycle after a frame. It is not asserted when a back-to-back load continued the stream.
- `busy` = (state != IDLE).
- Reset mid-frame: the frame is aborted with no `done` pulse. All outputs return to reset values on the cycle after the reset edge.
- Reset values: `load_ready`=1, `x`=0, `x_valid`=0, `busy`=0, `done`=0, state IDLE, shift register and counter 0.

## Timing
- Latency: a load accepted at edge k puts the first bit on `x` (`x_valid`=1) for cycle k+1 through k+2.
- A frame of `n` bits occupies `n` consecutive cycles, or `n+1` with parity.
- A back-to-back accept on the final-bit cycle makes the first bit of the next frame follow with zero idle cycles.
- A non-back-to-back frame gives exactly one IDLE cycle, carrying the `done` pulse, before a new accept can take effect. If `load_valid` is held high in IDLE, the accept happens on the same edge as the `done` pulse.
- All outputs are registered. There is no combinational path from `load_*` to `x`/`x_valid`.
- `load_ready` is a registered decode of state and counter.

## Configuration
- `SERIAL_PATTERN_GEN_PARITY_EN`
  - Defined: the PARITY state is compiled in. After the data bits, one extra bit equal to the XOR of the `n` sent data bits (even parity) is sent with `x_valid`=1.
  - Undefined: there is no PARITY state, and frames are exactly `n` bits.

## Test plan
- Reset, then load `load_data`=0x0009, `load_len`=4 -> `x`=1,0,0,1 on 4 consecutive cycles starting 1 cycle after the accept. `done` pulses on the next cycle. A connected `moore_1001` asserts `y` after the pattern.
- `load_len`=0 with `load_data`=0xA5C3 (`WIDTH`=16) -> 16 bits 1010010111000011, then `done`. Also apply `load_len`=31 and check it clamps to 16 bits.
- `load_valid` held high, frames 0x2 (len 2) then 0x1 (len 2) -> `x`=1,0,0,1 with `x_valid` continuously high for 4 cycles. A single `done` pulses only after the second frame.
- Assert `reset` for 1 cycle after 3 bits of a 12-bit frame -> next cycle `x_valid`=0, `busy`=0, `load_ready`=1, and no `done` pulse.
- With `SERIAL_PATTERN_GEN_PARITY_EN`: 0x0007 len 3 -> `x`=1,1,1 then parity 1. 0x0009 len 4 -> 1,0,0,1 then parity 0. `load_ready` is high only on the parity cycle.
- `load_valid`=0 for 10 cycles after reset -> `x`=0, `x_valid`=0, `busy`=0, `done`=0, `load_ready`=1 throughout.
